sap1_out_display: RTL and testbench
===================================

// Module: sap1_out_display
// PURPOSE
//  Downstream stage of the SAP-1 CPU output port. Captures the accumulator byte when the CPU asserts LO
//  and converts it to 3 BCD digits with a sequential double-dabble, one iteration per clock.
//  Drives a 3-digit multiplexed 7-segment display and latches the CPU halt status for an indicator.
// PARAMETERS
//  REFRESH_DIV    16  clocks per digit slot in the display scan (>=2; use 4 in sim)
//  SEG_ACT_LOW    1   1: seg/an outputs active-low; 0: active-high
//  BLANK_LEAD     1   1: blank leading zero digits; units digit is never blanked
// PORTS
//  clk        in   1  system clock, same clock as the CPU
//  rst        in   1  asynchronous, active-low reset
//  lo         in   1  CPU output-register load strobe; sampled on rising edge
//  data_in    in   8  accumulator/W-bus byte, valid when lo=1
//  hlt        in   1  CPU HLT decode
//  out_reg    out  8  captured output byte (binary)
//  busy       out  1  high while a conversion is in progress
//  done       out  1  one-cycle pulse when the display BCD registers are updated
//  bcd        out  12 committed BCD {hundreds,tens,units}
//  seg        out  7  segments {g,f,e,d,c,b,a}
//  an         out  3  digit enables: an[0]=units, an[1]=tens, an[2]=hundreds
//  halted     out  1  sticky halt indicator
// BEHAVIOUR
//  Reset (rst=0, async): out_reg=0, bcd=0, busy=0, done=0, halted=0, state=IDLE, scan index=0, refresh
//   cnt=0, an=all off, seg=all off. All registers are cleared immediately and a conversion in flight is discarded.
//  FSM: IDLE -> CONV -> COMMIT -> IDLE.
//   IDLE: lo=1 at edge E0 -> out_reg<=data_in, shift reg<={12'b0,data_in}, iter<=0, state<=CONV.
//   CONV: edges E1..E8 each add 3 to every BCD nibble >=5, then shift left 1. iter counts 0..7.
//    When iter=7, state<=COMMIT.
//   COMMIT: edge E9 -> bcd<=shift[19:8], done=1 for the cycle after E9, state<=IDLE.
//  busy=1 from after E0 through E9; the latency from lo to bcd valid is 10 edges.
//  lo=1 while in CONV or COMMIT: abort and restart. out_reg and the shift reg reload from data_in,
//   iter<=0, state<=CONV. The old conversion never commits and done does not pulse.
//  lo=1 in IDLE on the same edge done is high: a normal new capture.
//  Widths: shift reg is 20b {hund[3:0],tens[3:0],units[3:0],bin[7:0]}. Max value 255 -> 2/5/5, so no overflow.
//  Scan: refresh cnt counts 0..REFRESH_DIV-1. On wrap, the scan index advances 0->1->2->0 (wrap after 2).
//   an and seg are registered. They update on the edge after a reset release and show the current index.
//  Segment map (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//   BCD values 10-15 are unreachable; they decode as blank. If SEG_ACT_LOW=1, invert seg and an.
//  Blanking (BLANK_LEAD=1): hundreds is blank if 0. Tens is blank if hundreds=0 and tens=0.
//   A blanked digit has its anode enabled and all segments off.
//  Display always shows the last committed bcd and never shows partial conversion data.
//  halted: set on any edge with hlt=1. It clears only on reset.
// STRUCTURE
//  Shared package sap1_pkg holds:
//   the FSM state encoding (IDLE=2'd0, CONV=2'd1, COMMIT=2'd2),
//   the SEG_* digit constants and SEG_BLANK=7'h00,
//   the data width constant DATA_W=8.
//  Sub-module sap1_seg_decoder: purely combinational, 4b BCD + blank -> 7b active-high segments.
//   It is instantiated once on the muxed digit. Polarity inversion stays in the top.
//  The remaining logic (FSM, double-dabble datapath, scan counter, halt latch) is in the top level.
// TESTING (REFRESH_DIV=4, SEG_ACT_LOW=1, BLANK_LEAD=1)
//  1. Release reset, idle 12 clks -> bcd=000. an cycles 110,101,011 every 4 clks.
//     Units seg=7'h40, tens/hundreds seg=7'h7F.
//  2. lo=1, data_in=8'hFF for 1 clk -> busy for 10 edges, a single done pulse, bcd=12'h255, out_reg=FF.
//     Units and tens seg=7'h12, hundreds seg=7'h24.
//  3. data_in=8'd7 -> bcd=12'h007. Hundreds and tens blank (7'h7F), units seg=7'h78.
//  4. Load 8'd100, then 8'd42 on the 3rd CONV edge -> no done for 100.
//     One done 10 edges after the second lo, bcd=12'h042, hundreds blank.
//  5. Load 8'd200, assert rst mid-CONV (iter=4) -> all outputs are at reset values at once.
//     After release, bcd=000 and no done pulse.
//  6. hlt=1 for 1 clk -> halted=1 stays high across later lo loads. rst -> halted=0.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 output display stage: FSM encoding,
// datapath widths, 7-segment digit patterns and the double-dabble step.
package sap1_pkg;

  localparam int DATA_W  = 8;
  localparam int BCD_W   = 12;
  localparam int SHIFT_W = BCD_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
  // the whole {hund,tens,units,bin} register left by one.
  function automatic logic [SHIFT_W-1:0] dd_step(input logic [SHIFT_W-1:0] s);
    logic [SHIFT_W-1:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[DATA_W+4*i +: 4] >= 4'd5) begin
        t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
      end
    end
    return {t[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/sap1_seg_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Codes 10..15 cannot come out of the converter and are shown blank.
module sap1_seg_decoder
  import sap1_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup with forced blank override
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sap1_out_display.sv
// SAP-1 output port display stage: captures the accumulator byte on LO,
// converts it to BCD with a one-bit-per-clock double-dabble, and scans the
// committed value onto a 3-digit multiplexed 7-segment display. Also holds
// a sticky halt indicator.
//
// state  | meaning
// IDLE   | waiting for lo; display shows last committed value
// CONV   | 8 double-dabble iterations, iter 0..7
// COMMIT | copy converted BCD to bcd, pulse done on the following cycle
module sap1_out_display
  import sap1_pkg::*;
#(
  parameter int REFRESH_DIV = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int BLANK_LEAD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lo,
  input  logic [DATA_W-1:0] data_in,
  input  logic              hlt,
  output logic [DATA_W-1:0] out_reg,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output logic [6:0]        seg,
  output logic [2:0]        an,
  output logic              halted
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = (SEG_ACT_LOW != 0) ? 3'b111 : 3'b000;

  state_t              state_q, state_d;
  logic [2:0]          iter_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [DATA_W-1:0]   out_reg_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                done_q;
  logic                commit_en;
  logic                halted_q;

  logic [CNT_W-1:0]    refresh_cnt;
  logic [1:0]          scan_idx;
  logic [3:0]          digit_sel;
  logic                blank_sel;
  logic [6:0]          seg_raw;
  logic [2:0]          an_raw;
  logic [6:0]          seg_q;
  logic [2:0]          an_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a load strobe in any state (re)starts a conversion
  always_comb begin
    state_d   = state_q;
    commit_en = 1'b0;
    if (lo) begin
      state_d = CONV;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CONV:    if (iter_q == 3'd7) state_d = COMMIT;
        COMMIT: begin
          state_d   = IDLE;
          commit_en = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Capture, double-dabble iteration and commit of the BCD result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg_q <= '0;
      shift_q   <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      if (lo) begin
        out_reg_q <= data_in;
        shift_q   <= {{BCD_W{1'b0}}, data_in};
        iter_q    <= '0;
      end else if (state_q == CONV) begin
        shift_q <= dd_step(shift_q);
        iter_q  <= iter_q + 3'd1;
      end
      done_q <= commit_en;
      if (commit_en) begin
        bcd_q <= shift_q[SHIFT_W-1:DATA_W];
      end
    end
  end

  // Sticky halt indicator, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (hlt) begin
      halted_q <= 1'b1;
    end
  end

  // Refresh prescaler and digit scan index 0 -> 1 -> 2 -> 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Digit select and leading-zero blanking from the committed value only
  always_comb begin
    digit_sel = 4'd0;
    blank_sel = 1'b1;
    an_raw    = 3'b000;
    case (scan_idx)
      2'd0: begin
        digit_sel = bcd_q[3:0];
        blank_sel = 1'b0;
        an_raw    = 3'b001;
      end
      2'd1: begin
        digit_sel = bcd_q[7:4];
        blank_sel = (BLANK_LEAD != 0) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        an_raw    = 3'b010;
      end
      2'd2: begin
        digit_sel = bcd_q[11:8];
        blank_sel = (BLANK_LEAD != 0) && (bcd_q[11:8] == 4'd0);
        an_raw    = 3'b100;
      end
      default: begin
        digit_sel = 4'd0;
        blank_sel = 1'b1;
        an_raw    = 3'b000;
      end
    endcase
  end

  sap1_seg_decoder u_seg_decoder (
    .digit (digit_sel),
    .blank (blank_sel),
    .seg   (seg_raw)
  );

  // Registered display drive with output polarity applied
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else if (SEG_ACT_LOW != 0) begin
      seg_q <= ~seg_raw;
      an_q  <= ~an_raw;
    end else begin
      seg_q <= seg_raw;
      an_q  <= an_raw;
    end
  end

  assign out_reg = out_reg_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign seg     = seg_q;
  assign an      = an_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap1_out_display.sv
// Bench for sap1_out_display: directed scenarios plus random loads/aborts,
// checked against a decimal-arithmetic model of the displayed value.
module tb_sap1_out_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lo = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        hlt = 1'b0;
  logic [7:0]  out_reg;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tb_edges = 0;
  logic [6:0] seg_tab [10];

  sap1_out_display #(
    .REFRESH_DIV (4),
    .SEG_ACT_LOW (1),
    .BLANK_LEAD  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .lo      (lo),
    .data_in (data_in),
    .hlt     (hlt),
    .out_reg (out_reg),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .seg     (seg),
    .an      (an),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) tb_edges <= 0;
    else      tb_edges <= tb_edges + 1;
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int idx);
    int h, t, u, d;
    logic blank;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    d = u; blank = 1'b0;
    if (idx == 1) begin d = t; blank = (h == 0) && (t == 0); end
    if (idx == 2) begin d = h; blank = (h == 0); end
    return blank ? 7'h7F : ~seg_tab[d];
  endfunction

  // Watch the scan for 12 clocks while the displayed value is stable
  task automatic check_display(input int v, input string tag);
    int idx;
    logic [2:0] an_exp;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      idx = ((tb_edges - 1) / 4) % 3;
      an_exp = ~(3'b001 << idx);
      chk({tag, "_an"}, 32'(an), 32'(an_exp));
      chk({tag, "_seg"}, 32'(seg), 32'(model_seg(v, idx)));
    end
    @(posedge clk); #1;
  endtask

  // Drive lo for one edge; called and returns at #1 after a posedge
  task automatic do_load(input logic [7:0] v);
    lo = 1'b1; data_in = v;
    @(posedge clk); #1;
    lo = 1'b0; data_in = $urandom_range(0, 255);
  endtask

  // After the final lo: busy until commit, done 10 edges after lo
  task automatic wait_commit(input int v, input int dc0, input string tag);
    int n;
    bit seen;
    n = 0; seen = 0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (n < 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) seen = 1;
      else chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, 32'(n + 1), 32'd10);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'(model_bcd(v)));
    chk({tag, "_out_reg"}, 32'(out_reg), 32'(v));
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    int dc0, a, b, k;
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    // 1. reset values, then idle scan of 000
    #12;
    chk("rst_out_reg", 32'(out_reg), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_an", 32'(an), 32'h7);
    chk("rst_seg", 32'(seg), 32'h7F);
    @(negedge clk); rst = 1'b1;
    check_display(0, "idle");
    chk("idle_bcd", 32'(bcd), 32'd0);
    chk("idle_units_seg_model", 32'(model_seg(0, 0)), 32'h40);

    // 2. 255
    dc0 = done_cnt;
    do_load(8'hFF);
    wait_commit(255, dc0, "ff");
    check_display(255, "ff");

    // 3. 7
    dc0 = done_cnt;
    do_load(8'd7);
    wait_commit(7, dc0, "d7");
    check_display(7, "d7");

    // 4. 100 aborted by 42 on the third conversion edge
    dc0 = done_cnt;
    do_load(8'd100);
    repeat (2) begin @(posedge clk); #1; end
    do_load(8'd42);
    wait_commit(42, dc0, "abort");
    check_display(42, "abort");

    // 5. reset in the middle of a conversion
    dc0 = done_cnt;
    do_load(8'd200);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("midrst_out_reg", 32'(out_reg), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_an", 32'(an), 32'h7);
    chk("midrst_seg", 32'(seg), 32'h7F);
    @(negedge clk); rst = 1'b1;
    check_display(0, "postrst");
    chk("postrst_bcd", 32'(bcd), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_no_done", 32'(done_cnt - dc0), 32'd0);

    // Random loads, some aborted at a random edge (including COMMIT)
    for (int r = 0; r < 8; r++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      dc0 = done_cnt;
      do_load(8'(a));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 9);
        repeat (k - 1) begin @(posedge clk); #1; end
        do_load(8'(b));
        wait_commit(b, dc0, "rnd_abort");
        check_display(b, "rnd_abort");
      end else begin
        wait_commit(a, dc0, "rnd");
        check_display(a, "rnd");
      end
    end

    // 6. sticky halt
    chk("halt_before", 32'(halted), 32'd0);
    hlt = 1'b1;
    @(posedge clk); #1;
    hlt = 1'b0;
    chk("halt_set", 32'(halted), 32'd1);
    dc0 = done_cnt;
    do_load(8'd99);
    wait_commit(99, dc0, "halt_load");
    chk("halt_held", 32'(halted), 32'd1);
    rst = 1'b0;
    #1;
    chk("halt_cleared", 32'(halted), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("halt_stays_clear", 32'(halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
